// File: rtl/odd_issue_ctrl_pkg.sv
// Shared odd-pipe definitions: unit encodings, register addressing, default
// latencies and the decoded instruction bundle used by the issue stage.
package spu_pkg;

  localparam logic [1:0] UNIT_P1  = 2'b00;
  localparam logic [1:0] UNIT_LS1 = 2'b01;
  localparam logic [1:0] UNIT_BR1 = 2'b10;

  localparam int REG_AW   = 7;
  localparam int NUM_REGS = 1 << REG_AW;

  localparam int DEF_P1_LAT  = 4;
  localparam int DEF_LS1_LAT = 6;
  localparam int DEF_BR1_LAT = 1;
  localparam int DEF_CNT_W   = 3;

  typedef logic [0:REG_AW-1] reg_addr_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } hold_state_e;

  typedef struct packed {
    logic [0:10] op_code;
    logic [2:0]  instr_format;
    logic [1:0]  unit;
    reg_addr_t   rt;
    reg_addr_t   ra;
    reg_addr_t   rb;
    reg_addr_t   rc;
    logic [2:0]  src_used;
    logic        enable_reg_write;
    logic [7:0]  pc;
    logic        initial_;
  } odd_instr_t;

endpackage

// File: rtl/odd_issue_ctrl_if.sv
// Decode-side handshake plus the registered odd-pipe instruction outputs.
interface odd_issue_ctrl_if;
  import spu_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [0:10] in_op_code;
  logic [2:0]  in_instr_format;
  logic [1:0]  in_unit;
  reg_addr_t   in_dest_reg_addr;
  reg_addr_t   in_src_a_addr;
  reg_addr_t   in_src_b_addr;
  reg_addr_t   in_src_c_addr;
  logic [2:0]  in_src_used;
  logic        in_enable_reg_write;
  logic [7:0]  in_pc;
  logic        in_initial;
  logic        branch_is_taken;

  logic [0:10] op_code;
  logic [2:0]  instr_format;
  logic [1:0]  unit;
  reg_addr_t   dest_reg_addr;
  logic        enable_reg_write;
  logic [7:0]  program_counter_input;
  logic        initial_;
  logic        issue_valid;
  logic [15:0] stall_cycles;

  modport master (
    output in_valid, in_op_code, in_instr_format, in_unit, in_dest_reg_addr,
           in_src_a_addr, in_src_b_addr, in_src_c_addr, in_src_used,
           in_enable_reg_write, in_pc, in_initial, branch_is_taken,
    input  in_ready, op_code, instr_format, unit, dest_reg_addr, enable_reg_write,
           program_counter_input, initial_, issue_valid, stall_cycles
  );

  modport slave (
    input  in_valid, in_op_code, in_instr_format, in_unit, in_dest_reg_addr,
           in_src_a_addr, in_src_b_addr, in_src_c_addr, in_src_used,
           in_enable_reg_write, in_pc, in_initial, branch_is_taken,
    output in_ready, op_code, instr_format, unit, dest_reg_addr, enable_reg_write,
           program_counter_input, initial_, issue_valid, stall_cycles
  );

endinterface

// File: rtl/odd_scoreboard.sv
// Per-register countdown of cycles until an in-flight odd-pipe result is
// reachable on the forwarding path; a zero count means the operand is ready.
module odd_scoreboard
  import spu_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  reg_addr_t [2:0]       i_rd_addr,
  output logic      [2:0]       o_rd_ready,
  input  logic                  i_ld_en,
  input  reg_addr_t             i_ld_addr,
  input  logic      [CNT_W-1:0] i_ld_val
);

  logic [CNT_W-1:0] r_cnt [NUM_REGS];

  always_comb begin
    o_rd_ready = '0;
    for (int p = 0; p < 3; p++) begin
      o_rd_ready[p] = (r_cnt[i_rd_addr[p]] == '0);
    end
  end

  // A load always wins over the decrement so the youngest producer sets the wait.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i_ld_en && (i_ld_addr == REG_AW'(i))) begin
          r_cnt[i] <= i_ld_val;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/odd_issue_ctrl.sv
// Odd-pipe issue stage: one-entry holding register, RAW hazard check against
// the scoreboard, and registered instruction fields toward p1/ls1/br1.
module odd_issue_ctrl
  import spu_pkg::*;
#(
  parameter int P1_LAT  = DEF_P1_LAT,
  parameter int LS1_LAT = DEF_LS1_LAT,
  parameter int BR1_LAT = DEF_BR1_LAT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input logic              clock,
  input logic              reset,
  odd_issue_ctrl_if.slave  bus
);

  hold_state_e      r_state;
  odd_instr_t       r_hold;
  logic [0:10]      r_op_code;
  logic [2:0]       r_instr_format;
  logic [1:0]       r_unit;
  reg_addr_t        r_dest;
  logic             r_wen;
  logic [7:0]       r_pc;
  logic             r_initial;
  logic             r_issue_valid;
  logic [15:0]      r_stall_cycles;

  odd_instr_t       w_in;
  odd_instr_t       w_cand;
  logic             w_held;
  logic             w_cand_valid;
  logic             w_srcs_ready;
  logic             w_can_issue;
  logic [2:0]       w_rd_ready;
  reg_addr_t [2:0]  w_rd_addr;
  logic [CNT_W-1:0] w_ld_val;

  assign w_in = '{
    op_code:          bus.in_op_code,
    instr_format:     bus.in_instr_format,
    unit:             bus.in_unit,
    rt:               bus.in_dest_reg_addr,
    ra:               bus.in_src_a_addr,
    rb:               bus.in_src_b_addr,
    rc:               bus.in_src_c_addr,
    src_used:         bus.in_src_used,
    enable_reg_write: bus.in_enable_reg_write,
    pc:               bus.in_pc,
    initial_:         bus.in_initial
  };

  assign w_held       = (r_state == ST_HELD);
  assign w_cand       = w_held ? r_hold : w_in;
  assign w_cand_valid = w_held || bus.in_valid;
  assign w_rd_addr    = {w_cand.ra, w_cand.rb, w_cand.rc};
  assign w_srcs_ready = &(~w_cand.src_used | w_rd_ready);
  assign w_can_issue  = w_cand_valid && w_srcs_ready && !bus.branch_is_taken;
  assign bus.in_ready = !w_held || w_can_issue || bus.branch_is_taken;

  // Counter value is LAT-1 so a consumer issues exactly LAT cycles after its producer.
  always_comb begin
    w_ld_val = CNT_W'(P1_LAT - 1);
    case (w_cand.unit)
      UNIT_LS1: w_ld_val = CNT_W'(LS1_LAT - 1);
      UNIT_BR1: w_ld_val = CNT_W'(BR1_LAT - 1);
      default:  w_ld_val = CNT_W'(P1_LAT - 1);
    endcase
  end

  odd_scoreboard #(.CNT_W(CNT_W)) u_scoreboard (
    .clock      (clock),
    .reset      (reset),
    .i_rd_addr  (w_rd_addr),
    .o_rd_ready (w_rd_ready),
    .i_ld_en    (w_can_issue && w_cand.enable_reg_write),
    .i_ld_addr  (w_cand.rt),
    .i_ld_val   (w_ld_val)
  );

  // Flush beats issue beats stall; an issuing held entry can be refilled in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_EMPTY;
      r_hold         <= '0;
      r_op_code      <= '0;
      r_instr_format <= '0;
      r_unit         <= '0;
      r_dest         <= '0;
      r_wen          <= 1'b0;
      r_pc           <= '0;
      r_initial      <= 1'b0;
      r_issue_valid  <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_issue_valid <= 1'b0;
      r_wen         <= 1'b0;
      if (bus.branch_is_taken) begin
        r_state <= ST_EMPTY;
      end else if (w_can_issue) begin
        r_op_code      <= w_cand.op_code;
        r_instr_format <= w_cand.instr_format;
        r_unit         <= w_cand.unit;
        r_dest         <= w_cand.rt;
        r_wen          <= w_cand.enable_reg_write;
        r_pc           <= w_cand.pc;
        r_initial      <= w_cand.initial_;
        r_issue_valid  <= 1'b1;
        if (w_held && bus.in_valid) begin
          r_state <= ST_HELD;
          r_hold  <= w_in;
        end else begin
          r_state <= ST_EMPTY;
        end
      end else if (w_cand_valid) begin
        r_state <= ST_HELD;
        r_hold  <= w_cand;
        if (r_stall_cycles != 16'hFFFF) begin
          r_stall_cycles <= r_stall_cycles + 16'd1;
        end
      end
    end
  end

  assign bus.op_code               = r_op_code;
  assign bus.instr_format          = r_instr_format;
  assign bus.unit                  = r_unit;
  assign bus.dest_reg_addr         = r_dest;
  assign bus.enable_reg_write      = r_wen;
  assign bus.program_counter_input = r_pc;
  assign bus.initial_              = r_initial;
  assign bus.issue_valid           = r_issue_valid;
  assign bus.stall_cycles          = r_stall_cycles;

endmodule

// File: tb/tb_odd_issue_ctrl.sv
// Scoreboard bench for odd_issue_ctrl: stimulus pushes expected issues with
// their hand-computed issue cycle, a negedge monitor pops and compares.
module tb_odd_issue_ctrl;
  import spu_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic [0:10] op;
    logic [2:0]  fmt;
    logic [1:0]  unit;
    logic [0:6]  rt;
    logic        we;
    logic [7:0]  pc;
    logic        init;
    int          cyc;
  } exp_t;

  exp_t expq[$];
  exp_t monE;

  odd_issue_ctrl_if bus();

  odd_issue_ctrl #(
    .P1_LAT  (4),
    .LS1_LAT (6),
    .BR1_LAT (1),
    .CNT_W   (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Every issued instruction must match the oldest expectation, on its exact cycle.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.issue_valid) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected issue", 64'(bus.issue_valid), 64'(0));
        end else begin
          monE = expq.pop_front();
          checkOutput("issue cycle", 64'(cyc), 64'(monE.cyc));
          checkOutput("op_code", 64'(bus.op_code), 64'(monE.op));
          checkOutput("instr_format", 64'(bus.instr_format), 64'(monE.fmt));
          checkOutput("unit", 64'(bus.unit), 64'(monE.unit));
          checkOutput("dest_reg_addr", 64'(bus.dest_reg_addr), 64'(monE.rt));
          checkOutput("enable_reg_write", 64'(bus.enable_reg_write), 64'(monE.we));
          checkOutput("pc", 64'(bus.program_counter_input), 64'(monE.pc));
          checkOutput("initial_", 64'(bus.initial_), 64'(monE.init));
        end
      end else begin
        checkOutput("idle enable_reg_write", 64'(bus.enable_reg_write), 64'(0));
      end
    end
  end

  // delay > 0: expected issue this many cycles after the offer; 0: must never issue.
  task automatic applyStimulus(input logic [0:10] op, input logic [1:0] unit,
                               input logic [0:6] rt, input logic [0:6] ra,
                               input logic [0:6] rb, input logic [0:6] rc,
                               input logic [2:0] used, input logic we,
                               input logic [7:0] pc, input int delay);
    exp_t e;
    bus.in_valid            = 1'b1;
    bus.in_op_code          = op;
    bus.in_instr_format     = pc[2:0];
    bus.in_unit             = unit;
    bus.in_dest_reg_addr    = rt;
    bus.in_src_a_addr       = ra;
    bus.in_src_b_addr       = rb;
    bus.in_src_c_addr       = rc;
    bus.in_src_used         = used;
    bus.in_enable_reg_write = we;
    bus.in_pc               = pc;
    bus.in_initial          = pc[0];
    if (delay > 0) begin
      e = '{op, pc[2:0], unit, rt, we, pc, pc[0], cyc + delay};
      expq.push_back(e);
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkReady(input string name, input logic req);
    #1;
    checkOutput(name, 64'(bus.in_ready), 64'(req));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " issue_valid"}, 64'(bus.issue_valid), 64'(0));
    checkOutput({tag, " enable_reg_write"}, 64'(bus.enable_reg_write), 64'(0));
    checkOutput({tag, " op_code"}, 64'(bus.op_code), 64'(0));
    checkOutput({tag, " dest_reg_addr"}, 64'(bus.dest_reg_addr), 64'(0));
    checkOutput({tag, " pc"}, 64'(bus.program_counter_input), 64'(0));
    checkOutput({tag, " stall_cycles"}, 64'(bus.stall_cycles), 64'(0));
    checkReady({tag, " in_ready"}, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_valid            = 1'b0;
    bus.in_op_code          = '0;
    bus.in_instr_format     = '0;
    bus.in_unit             = '0;
    bus.in_dest_reg_addr    = '0;
    bus.in_src_a_addr       = '0;
    bus.in_src_b_addr       = '0;
    bus.in_src_c_addr       = '0;
    bus.in_src_used         = '0;
    bus.in_enable_reg_write = 1'b0;
    bus.in_pc               = '0;
    bus.in_initial          = 1'b0;
    bus.branch_is_taken     = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    checkResetState("reset");

    $display("[TB] independent stream");
    for (int i = 0; i < 5; i++) begin
      checkOutput("stream in_ready", 64'(bus.in_ready), 64'(1));
      applyStimulus(11'(i + 1), UNIT_P1, 7'(20 + i), 7'(30 + i), 7'd0, 7'd0,
                    3'b100, 1'b1, 8'(i + 1), 1);
    end
    idle(8);
    checkOutput("stream stall_cycles", 64'(bus.stall_cycles), 64'(0));

    $display("[TB] ls1 RAW on r10");
    applyStimulus(11'h010, UNIT_LS1, 7'd10, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 8'h10, 1);
    applyStimulus(11'h011, UNIT_P1, 7'd11, 7'd0, 7'd10, 7'd0, 3'b010, 1'b0, 8'h11, 6);
    checkReady("ls1 stall in_ready early", 1'b0);
    idle(3);
    checkReady("ls1 stall in_ready late", 1'b0);
    idle(1);
    checkReady("ls1 release in_ready", 1'b1);
    idle(8);
    checkOutput("ls1 stall_cycles", 64'(bus.stall_cycles), 64'(5));

    $display("[TB] p1 RAW and br1 RAW");
    applyStimulus(11'h020, UNIT_P1, 7'd3, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 8'h20, 1);
    applyStimulus(11'h021, UNIT_P1, 7'd12, 7'd3, 7'd0, 7'd0, 3'b100, 1'b1, 8'h21, 4);
    idle(8);
    checkOutput("p1 stall_cycles", 64'(bus.stall_cycles), 64'(8));
    applyStimulus(11'h022, UNIT_BR1, 7'd4, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 8'h22, 1);
    applyStimulus(11'h023, UNIT_P1, 7'd13, 7'd0, 7'd0, 7'd4, 3'b001, 1'b0, 8'h23, 1);
    idle(8);
    checkOutput("br1 stall_cycles", 64'(bus.stall_cycles), 64'(8));

    $display("[TB] WAW on r7");
    applyStimulus(11'h030, UNIT_LS1, 7'd7, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 8'h30, 1);
    applyStimulus(11'h031, UNIT_BR1, 7'd7, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 8'h31, 1);
    applyStimulus(11'h032, UNIT_P1, 7'd14, 7'd7, 7'd0, 7'd0, 3'b100, 1'b0, 8'h32, 1);
    idle(8);
    checkOutput("waw stall_cycles", 64'(bus.stall_cycles), 64'(8));

    $display("[TB] flush while stalled");
    applyStimulus(11'h040, UNIT_LS1, 7'd10, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 8'h40, 1);
    applyStimulus(11'h041, UNIT_P1, 7'd15, 7'd10, 7'd0, 7'd0, 3'b100, 1'b1, 8'h41, 0);
    bus.branch_is_taken = 1'b1;
    checkReady("flush in_ready", 1'b1);
    applyStimulus(11'h042, UNIT_P1, 7'd16, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 8'h42, 0);
    bus.branch_is_taken = 1'b0;
    checkOutput("post-flush issue_valid", 64'(bus.issue_valid), 64'(0));
    checkReady("post-flush in_ready", 1'b1);
    applyStimulus(11'h043, UNIT_P1, 7'd17, 7'd10, 7'd0, 7'd0, 3'b100, 1'b0, 8'h43, 4);
    idle(8);
    checkOutput("flush stall_cycles", 64'(bus.stall_cycles), 64'(12));

    $display("[TB] reset while stalled");
    applyStimulus(11'h050, UNIT_LS1, 7'd10, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 8'h50, 1);
    applyStimulus(11'h051, UNIT_P1, 7'd18, 7'd10, 7'd0, 7'd0, 3'b100, 1'b1, 8'h51, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkResetState("mid-stall reset");
    applyStimulus(11'h052, UNIT_P1, 7'd19, 7'd10, 7'd0, 7'd0, 3'b100, 1'b0, 8'h52, 1);
    idle(8);
    checkOutput("queue drained", 64'(expq.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
